dot_accumulate: RTL
===================

Name: dot_accumulate

Overview:
- Downstream consumer of the multiply stage. Sums a stream of signed products over VEC_LEN beats to form one dot product (e.g. one Q·K score across the head dimension).
- Emits the result through a one-entry output register.
- Uses the same vld/rdy handshake as the multiply stage, so it chains directly onto multiply's vld_out/product.

Parameters:
- W_IN, 2*`INTEGER_WIDTH, width of signed product input.
- VEC_LEN, 64, products per dot product; must be ≥ 2.
- W_ACC, W_IN+$clog2(VEC_LEN), internal accumulator width; guarantees no internal overflow.
- W_OUT, W_ACC, width of sum_out; must be ≤ W_ACC.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous abort of the partial vector.
- vld_in  input  1  upstream product valid.
- rdy_in  input  1  downstream ready for sum_out.
- vld_out  output  1  sum_out valid.
- rdy_out  output  1  ready to accept a product.
- product_in  input  W_IN  signed product.
- sum_out  output  W_OUT  signed dot-product result.
- busy  output  1  high while a partial vector is held (cnt != 0).

Behaviour:
- Reset (rst=0, async, asserted any time including mid-vector):
  - acc=0, cnt=0, sum_out=0, vld_out=0.
  - rdy_out=1 combinationally after release; busy=0.
  - A partial vector in progress is discarded.
- State: cnt (0..VEC_LEN-1), acc (W_ACC signed), output register {vld_out, sum_out}. Two effective states:
  - ACCUM: cnt < VEC_LEN-1.
  - LAST: cnt == VEC_LEN-1.
- rdy_out:
  - Low whenever clr=1.
  - In ACCUM, otherwise always 1.
  - In LAST: rdy_out = !vld_out || rdy_in. The final beat is accepted only if the output slot is empty or draining this cycle.
- Beat accept = vld_in && rdy_out. product_in is sign-extended to W_ACC.
  - ACCUM accept: acc <= acc + product_in; cnt <= cnt+1.
  - LAST accept:
    - sum_out <= resize(acc + product_in); vld_out <= 1.
    - acc <= 0; cnt <= 0.
- Output drain: if vld_out && rdy_in and no LAST accept this cycle, vld_out <= 0; sum_out holds its value.
  - A simultaneous drain and LAST accept leaves vld_out=1 with the new sum. No bubble, no loss.
- Output hold: while vld_out=1 and rdy_in=0, sum_out and vld_out are stable.
- clr=1:
  - acc <= 0; cnt <= 0; no beat is accepted that cycle.
  - The output register is unaffected; drain still proceeds.
- Latency: sum_out is valid the cycle after the final beat is accepted.
- Throughput: 1 product/cycle sustained, back-to-back vectors with no gap when rdy_in=1.
- Bubbles (vld_in=0) change neither acc nor cnt.
- resize: low W_OUT bits of the W_ACC sum (two's-complement truncation). Identity when W_OUT == W_ACC.

Optional Feature:
- Macro DOT_ACCUMULATE_SAT_EN.
- Defined: resize saturates to the signed W_OUT range [-2^(W_OUT-1), 2^(W_OUT-1)-1] instead of truncating.
- Not defined: plain truncation.
- Accumulator behaviour and timing are identical in both cases.

Test Plan:
- Reset mid-vector:
  - Stimulus: VEC_LEN=4, W_IN=16. Feed 2 beats, assert rst=0 asynchronously between clock edges.
  - Required: vld_out=0, sum_out=0, busy=0 immediately; rdy_out=1 after release.
  - Then feed 1,2,3,4: sum_out=10.
- Back-to-back vectors:
  - Stimulus: products 3,-5,7,10 then 1,1,1,1 on 8 consecutive cycles, rdy_in=1.
  - Required: vld_out=1 with sum_out=15 the cycle after beat 4; sum_out=4 the cycle after beat 8; vld_out=0 the following cycle.
- Backpressure:
  - Stimulus: rdy_in=0; vector 1,1,1,1 completes, then vector 2,2,2,2.
  - Required: sum_out=4 held stable; rdy_out=0 on the 4th beat of the second vector.
  - Raise rdy_in: 4 drains and the beat is accepted the same cycle; next cycle vld_out=1 with sum_out=8.
- Bubbles and clr:
  - Stimulus: 100,100 accepted, then clr=1 for one cycle with vld_in=1 (beat not accepted), then 5,bubble,6,bubble,7,8.
  - Required: sum_out=26; busy=0 after clr.
- Extremes:
  - Stimulus: four beats of -32768 with W_ACC=18.
  - Required: sum_out=-131072.
  - With W_OUT=16, macro undefined: sum_out=0 (truncated).
  - With W_OUT=16, DOT_ACCUMULATE_SAT_EN defined: sum_out=-32768.
  - Four beats of 32767: saturated sum_out=32767.

Source files
------------

// File: rtl/dot_accumulate.sv
// Streaming signed dot-product accumulator: sums VEC_LEN products per result and holds each result in a one-entry output slot.
// Optional macro DOT_ACCUMULATE_SAT_EN: saturate instead of truncate when W_OUT < W_ACC.
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

module dot_accumulate #(
  parameter int W_IN    = 2*`INTEGER_WIDTH,
  parameter int VEC_LEN = 64,
  parameter int W_ACC   = W_IN + $clog2(VEC_LEN),
  parameter int W_OUT   = W_ACC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             vld_in,
  input  logic             rdy_in,
  output logic             vld_out,
  output logic             rdy_out,
  input  logic [W_IN-1:0]  product_in,
  output logic [W_OUT-1:0] sum_out,
  output logic             busy
);
  localparam int CW = $clog2(VEC_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(VEC_LEN-1);

  logic [CW-1:0]           cnt;
  logic signed [W_ACC-1:0] acc, prod_ext, sum_full;
  logic [W_OUT-1:0]        sum_rsz;
  logic                    is_last, accept, last_accept;

  assign is_last     = cnt == LAST_CNT;
  // The final beat may only land when the output slot is free or draining now.
  assign rdy_out     = !clr && (!is_last || !vld_out || rdy_in);
  assign accept      = vld_in && rdy_out;
  assign last_accept = accept && is_last;
  assign busy        = cnt != '0;
  assign prod_ext    = W_ACC'($signed(product_in));
  assign sum_full    = acc + prod_ext;

`ifdef DOT_ACCUMULATE_SAT_EN
  logic [W_ACC-W_OUT:0] hi;
  assign hi = sum_full[W_ACC-1:W_OUT-1];
  // Bits above the output sign bit disagree -> value is out of range.
  always_comb begin
    sum_rsz = sum_full[W_OUT-1:0];
    if (!(&hi) && (|hi))
      sum_rsz = sum_full[W_ACC-1] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}};
  end
`else
  assign sum_rsz = sum_full[W_OUT-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr || last_accept) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= sum_full;
      cnt <= cnt + CW'(1);
    end
  end

  // A new result overrides a drain in the same cycle, so back-to-back vectors never bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_out <= 1'b0;
      sum_out <= '0;
    end else if (last_accept) begin
      vld_out <= 1'b1;
      sum_out <= sum_rsz;
    end else if (vld_out && rdy_in) begin
      vld_out <= 1'b0;
    end
  end
endmodule
